// File: rtl/sdes_pkg.sv
// Shared definitions for the iterative S-DES engine.
//   - Permutation tables in the textbook 1-based, MSB-first notation
//     (entry j names the source bit feeding output bit j, bit 1 = MSB).
//   - S0/S1 substitution boxes, flattened as {row, col}.
//   - FSM state encoding.
//   - Permutation helpers, 5-bit rotate and the mod-5 shift-pointer schedule.
package sdes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int P10_TAB    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_TAB     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int P4_TAB     [4]  = '{2, 4, 3, 1};
  localparam int IP_TAB     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IP_INV_TAB [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_TAB     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};

  // Row is {outer bits}, column is {inner bits} of the 4-bit input.
  localparam logic [1:0] S0_TAB [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_TAB [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3};

  // Shift-pointer steps: encrypt walks the schedule forward (+2 mod 5),
  // decrypt walks it backward (+3 mod 5 == -2 mod 5).
  localparam logic [2:0] SH_STEP_ENC = 3'd2;
  localparam logic [2:0] SH_STEP_DEC = 3'd3;

  // Outputs are shifted in MSB first, so table entry 0 lands on the MSB.
  function automatic logic [9:0] p10(input logic [9:0] k);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[8:0], k[4'(10 - P10_TAB[4'(i)])]};
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], k[4'(10 - P8_TAB[3'(i)])]};
    return r;
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], x[3'(8 - IP_TAB[3'(i)])]};
    return r;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], x[3'(8 - IP_INV_TAB[3'(i)])]};
    return r;
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[6:0], x[2'(4 - EP_TAB[3'(i)])]};
    return r;
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = {r[2:0], x[2'(4 - P4_TAB[2'(i)])]};
    return r;
  endfunction

  function automatic logic [1:0] s0(input logic [3:0] x);
    return S0_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] x);
    return S1_TAB[{x[3], x[0], x[2], x[1]}];
  endfunction

  function automatic logic [4:0] rotl5(input logic [4:0] v, input logic [2:0] n);
    case (n)
      3'd1:    return {v[3:0], v[4]};
      3'd2:    return {v[2:0], v[4:3]};
      3'd3:    return {v[1:0], v[4:2]};
      3'd4:    return {v[0], v[4:1]};
      default: return v;
    endcase
  endfunction

  function automatic logic [2:0] sh_step(input logic [2:0] sh, input logic [2:0] step);
    logic [3:0] t;
    t = {1'b0, sh} + {1'b0, step};
    if (t >= 4'd5) t = t - 4'd5;
    return t[2:0];
  endfunction

  // Cumulative rotation for round n: c_1 = 1, c_n = c_{n-1} + 2 (mod 5).
  function automatic logic [2:0] sh_at_round(input int n);
    return 3'((2 * n - 1) % 5);
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// S-DES round function fk (combinational).
//   blk      : current block {L, R}
//   k        : 8-bit round subkey
//   blk_next : {L ^ F(R, k), R}; the half swap is left to the caller
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [7:0] blk,
  input  logic [7:0] k,
  output logic [7:0] blk_next
);

  logic [7:0] mix;
  logic [3:0] sbox_out;

  assign mix      = ep(blk[3:0]) ^ k;
  assign sbox_out = {s0(mix[7:4]), s1(mix[3:0])};
  assign blk_next = {blk[7:4] ^ p4(sbox_out), blk[3:0]};

endmodule

// File: rtl/sdes_iter_core.sv
// Iterative S-DES engine, one Feistel round per clock.
//   CLOCK_50  : system clock
//   rst       : synchronous, active-high reset
//   in_valid/in_ready   : input handshake (ready only while idle)
//   data_in, key_in     : block and raw 10-bit key, sampled at acceptance
//   decrypt             : 0 encrypt, 1 decrypt, sampled at acceptance
//   out_valid/out_ready : output handshake; data_out held until taken
//   busy                : high while rounds are in progress
// NUM_ROUNDS (1..15) sets the Feistel depth; 2 gives standard S-DES.
module sdes_iter_core
  import sdes_pkg::*;
#(
  parameter int NUM_ROUNDS = 2
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic [9:0] key_in,
  input  logic       decrypt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] END_RND  = 4'(NUM_ROUNDS);
  localparam logic [2:0] SH_DEC0  = sh_at_round(NUM_ROUNDS);

  state_t     state, state_nxt;
  logic       in_ready_r;
  logic [7:0] data_out_r;
  logic [3:0] rnd;
  logic [7:0] blk;
  logic [9:0] kreg;
  logic       mode;
  logic [2:0] sh;

  logic       accept;
  logic       round_en;
  logic       finish;
  logic [7:0] subkey;
  logic [7:0] fk_out;
  logic [7:0] blk_upd;

  assign accept = in_valid && in_ready_r && (state == IDLE);

  // Subkey derived from the unchanging key register and the shift pointer.
  assign subkey = p8({rotl5(kreg[9:5], sh), rotl5(kreg[4:0], sh)});

  sdes_fk u_fk (
    .blk      (blk),
    .k        (subkey),
    .blk_next (fk_out)
  );

  assign blk_upd = (rnd == LAST_RND) ? fk_out : {fk_out[3:0], fk_out[7:4]};

  // ROUND lasts NUM_ROUNDS+1 cycles: one per round, then one to publish.
  always_comb begin
    state_nxt = state;
    round_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = ROUND;
      ROUND: begin
        if (rnd == END_RND) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          round_en  = 1'b1;
        end
      end
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_r <= 1'b0;
      data_out_r <= 8'h00;
      rnd        <= 4'd0;
    end else begin
      state      <= state_nxt;
      in_ready_r <= (state_nxt == IDLE);
      if (accept)        rnd <= 4'd0;
      else if (round_en) rnd <= rnd + 4'd1;
      if (finish) data_out_r <= ip_inv(blk);
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      blk  <= ip(data_in);
      kreg <= p10(key_in);
      mode <= decrypt;
      sh   <= decrypt ? SH_DEC0 : 3'd1;
    end else if (round_en) begin
      blk  <= blk_upd;
      sh   <= sh_step(sh, mode ? SH_STEP_DEC : SH_STEP_ENC);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = (state == DONE);
  assign busy      = (state == ROUND);
  assign data_out  = data_out_r;

endmodule

// File: tb/tb_sdes_iter_core.sv
// Bench for sdes_iter_core: four instances with NUM_ROUNDS = 1, 2, 3, 5.
module tb_sdes_iter_core;

  logic            clk;
  logic            rst;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [3:0][7:0] data_in;
  logic [3:0][9:0] key_in;
  logic [3:0]      decrypt;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic [3:0][7:0] data_out;
  logic [3:0]      busy;

  int errors = 0;
  int checks = 0;

  localparam logic [9:0] KEY_A = 10'b1010000010;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NRG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 5;
    sdes_iter_core #(.NUM_ROUNDS(NRG)) u_dut (
      .CLOCK_50  (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .key_in    (key_in[g]),
      .decrypt   (decrypt[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int nr_of(input int u);
    case (u)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  localparam int S0M [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1M [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  // Reference S-DES with n rounds, written out with explicit bit selects.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [9:0] key,
                                       input logic dec, input int n);
    logic [9:0] t;
    logic [4:0] lh, rh;
    logic [7:0] ks [16];
    logic [7:0] b, e, k;
    logic [3:0] l, r, tmp, s;
    t  = {key[7], key[5], key[8], key[3], key[6], key[0], key[9], key[1], key[2], key[4]};
    lh = t[9:5];
    rh = t[4:0];
    for (int i = 0; i < 16; i++) ks[i] = 8'h00;
    for (int i = 1; i <= n; i++) begin
      repeat ((i == 1) ? 1 : 2) begin
        lh = {lh[3:0], lh[4]};
        rh = {rh[3:0], rh[4]};
      end
      t = {lh, rh};
      ks[i] = {t[4], t[7], t[3], t[6], t[2], t[5], t[0], t[1]};
    end
    b = {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
    l = b[7:4];
    r = b[3:0];
    for (int i = 0; i < n; i++) begin
      k = dec ? ks[n - i] : ks[i + 1];
      e = {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]} ^ k;
      s = {2'(S0M[{e[7], e[4]}][{e[6], e[5]}]), 2'(S1M[{e[3], e[0]}][{e[2], e[1]}])};
      l = l ^ {s[2], s[0], s[1], s[3]};
      if (i != n - 1) begin
        tmp = l;
        l   = r;
        r   = tmp;
      end
    end
    b = {l, r};
    return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic send(input int u, input logic dec, input logic [9:0] key,
                      input logic [7:0] d, output bit ok);
    int cnt;
    cnt = 0;
    decrypt[u]  = dec;
    key_in[u]   = key;
    data_in[u]  = d;
    in_valid[u] = 1'b1;
    while (!in_ready[u] && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    ok = in_ready[u];
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid[u] = 1'b0;
  endtask

  // Counts rising edges from acceptance until out_valid; -1 on timeout.
  task automatic wait_out(input int u, output int lat, output logic [7:0] res);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid[u]) break;
    end
    if (!out_valid[u]) lat = -1;
    res = data_out[u];
  endtask

  task automatic run_block(input int u, input logic dec, input logic [9:0] key,
                           input logic [7:0] d, output int lat, output logic [7:0] res);
    bit ok;
    out_ready[u] = 1'b1;
    send(u, dec, key, d, ok);
    if (!ok) begin
      lat = -1;
      res = 8'h00;
    end else begin
      wait_out(u, lat, res);
    end
  endtask

  task automatic rand_test(input int u);
    logic [9:0] key;
    logic [7:0] d, c, p;
    int lat;
    for (int ki = 0; ki < 32; ki++) begin
      key = 10'($urandom);
      for (int di = 0; di < 16; di++) begin
        d = 8'($urandom);
        run_block(u, 1'b0, key, d, lat, c);
        check("rand_enc", 32'(c), 32'(model(d, key, 1'b0, nr_of(u))));
        run_block(u, 1'b1, key, c, lat, p);
        check("rand_roundtrip", 32'(p), 32'(d));
        check("rand_latency", 32'(lat), 32'(nr_of(u) + 1));
      end
    end
  endtask

  typedef struct {
    int         u;
    logic       dec;
    logic [9:0] key;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int         lat;
    int         nres;
    int         nbad;
    bit         ok;
    bit         seen;
    logic [7:0] res;

    vecs[0] = '{u: 1, dec: 1'b0, key: KEY_A, din: 8'b01110010, dout: 8'b01110111};
    vecs[1] = '{u: 1, dec: 1'b1, key: KEY_A, din: 8'b01110111, dout: 8'b01110010};
    vecs[2] = '{u: 0, dec: 1'b0, key: KEY_A, din: 8'b01110010, dout: 8'b11010110};
    vecs[3] = '{u: 0, dec: 1'b1, key: KEY_A, din: 8'b11010110, dout: 8'b01110010};

    rst       = 1'b1;
    in_valid  = '0;
    decrypt   = '0;
    out_ready = '0;
    data_in   = '0;
    key_in    = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    rst = 1'b0;
    check("in_ready_before_edge", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'hF);

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      run_block(vecs[i].u, vecs[i].dec, vecs[i].key, vecs[i].din, lat, res);
      check($sformatf("vec%0d_out", i), 32'(res), 32'(vecs[i].dout));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(nr_of(vecs[i].u) + 1));
    end

    // Output held under back-pressure; in_valid during DONE ignored
    out_ready[1] = 1'b0;
    send(1, 1'b0, KEY_A, 8'b01110010, ok);
    wait_out(1, lat, res);
    check("hold_first_out", 32'(res), 32'h77);
    check("hold_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 10; c++) begin
      in_valid[1] = (c == 3 || c == 4);
      data_in[1]  = 8'hAA;
      @(posedge clk); #1;
      check("hold_state", 32'({out_valid[1], in_ready[1], busy[1], data_out[1]}),
            32'({1'b1, 1'b0, 1'b0, 8'h77}));
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("release_valid_ready", 32'({out_valid[1], in_ready[1]}), 32'b01);
    @(posedge clk); #1;
    check("no_ghost_block", 32'({busy[1], out_valid[1]}), 32'b00);

    // Reset on the second ROUND cycle
    send(1, 1'b0, KEY_A, 8'b01110010, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outputs", 32'({out_valid[1], busy[1], in_ready[1], data_out[1]}), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid[1]) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'h0);
    check("midrst_ready", 32'(in_ready[1]), 32'h1);
    run_block(1, 1'b1, KEY_A, 8'b01110111, lat, res);
    check("midrst_next_out", 32'(res), 32'h72);
    check("midrst_next_latency", 32'(lat), 32'd3);

    // Throughput with both handshakes held high
    decrypt[1]   = 1'b0;
    key_in[1]    = KEY_A;
    data_in[1]   = 8'b01110010;
    in_valid[1]  = 1'b1;
    out_ready[1] = 1'b1;
    nres = 0;
    nbad = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (out_valid[1]) begin
        nres++;
        if (data_out[1] !== 8'h77) nbad++;
      end
    end
    in_valid[1] = 1'b0;
    checks++;
    if (nres < 19 || nres > 21) begin
      errors++;
      $display("FAIL throughput_count: got %0d results, expected 20 +/- 1", nres);
    end
    check("throughput_values", 32'(nbad), 32'h0);
    repeat (10) @(posedge clk);
    #1;

    // Random round trips on all round counts
    fork
      rand_test(0);
      rand_test(1);
      rand_test(2);
      rand_test(3);
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
